upd7801_intc: RTL and testbench

Parametrised interrupt controller for the uPD780x CPU family. It replaces the bare `ie` flag with per-channel request latches, masking, edge/level detection, fixed priority, vector generation and a skip-on-interrupt test port (SKIT-style). It sits beside the CPU core, is clocked on the CPU clock, and is qualified by the same phase strobe the core uses for register updates.

---
 rtl/upd7801_intc_pkg.sv | 22 ++
 rtl/intc_chan.sv | 39 +++
 rtl/upd7801_intc.sv | 129 ++++++++++++
 tb/tb_upd7801_intc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/upd7801_intc_pkg.sv
// Shared types and helpers for the uPD780x interrupt controller.
package upd7801_intc_pkg;

    // Request/service handshake state seen by the CPU.
    typedef enum logic [1:0] {
        INTC_IDLE = 2'd0,
        INTC_PEND = 2'd1,
        INTC_SERV = 2'd2
    } e_intc_state;

    // Vector address of channel idx; the result deliberately wraps at 16 bits.
    function automatic logic [15:0] intc_vec(
        input logic [15:0] base,
        input logic [15:0] stride,
        input int unsigned idx
    );
        logic [15:0] idx16;
        idx16 = 16'(idx);
        return base + idx16 * stride;
    endfunction

endpackage

// File: rtl/intc_chan.sv
// One request channel: edge or level detection and the request flag latch.
module intc_chan #(
    parameter bit EDGE = 1'b1,   // 1 = edge-triggered, 0 = level
    parameter bit POL  = 1'b1    // 1 = rising / active-high, 0 = falling / active-low
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic irq_in,
    input  logic clr,            // ACK or test-port clear, edge channels only
    output logic flag
);

    logic prev;
    logic active;
    logic set;

    // Polarity-qualified level and transition of the raw request line.
    always_comb begin
        active = POL ? irq_in : ~irq_in;
        set    = POL ? (irq_in & ~prev) : (~irq_in & prev);
    end

    // Previous sample and flag latch; a new edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            prev <= 1'b0;
            flag <= 1'b0;
        end else if (ce) begin
            prev <= irq_in;
            if (EDGE)
                flag <= set | (flag & ~clr);
            else
                flag <= active;
        end
    end

endmodule

// File: rtl/upd7801_intc.sv
// uPD780x interrupt controller: channel latches, mask, priority, vector and test port.
module upd7801_intc
    import upd7801_intc_pkg::*;
#(
    parameter int                 NUM_IRQ    = 5,
    parameter bit                 NMI_CH0    = 1'b1,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE  = 5'b11110,
    parameter logic [NUM_IRQ-1:0] EDGE_POL   = 5'b11111,
    parameter logic [15:0]        VEC_BASE   = 16'h0004,
    parameter logic [15:0]        VEC_STRIDE = 16'h0004,
    localparam int                SEL_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    input  logic               IE_IN,
    input  logic               MASK_WE,
    input  logic [NUM_IRQ-1:0] MASK_D,
    input  logic               ACK,
    input  logic               TEST_STB,
    input  logic [SEL_W-1:0]   TEST_SEL,
    output logic               IRQ_REQ,
    output logic [15:0]        IRQ_VEC,
    output logic               TEST_HIT,
    output logic [NUM_IRQ-1:0] FLAGS,
    output logic [NUM_IRQ-1:0] MASK
);

    e_intc_state        state;
    e_intc_state        next_state;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] test_clr;
    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   win_idx;     // channel currently shown on IRQ_VEC
    logic               any_elig;
    logic               frozen_nmi;
    logic               sel_valid;
    logic               track_winner;

    // Per-channel detection and flag latches.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
        intc_chan #(
            .EDGE (EDGE_MODE[i]),
            .POL  (EDGE_POL[i])
        ) u_chan (
            .clk    (CLK),
            .reset  (RESET),
            .ce     (CE),
            .irq_in (IRQ_IN[i]),
            .clr    (ack_clr[i] | test_clr[i]),
            .flag   (FLAGS[i])
        );
    end

    // Eligibility and fixed-priority encoder; lowest index wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        elig     = '0;
        winner   = '0;
        any_elig = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++)
            elig[i] = FLAGS[i] & ((~MASK[i] & IE_IN) | ((i == 0) && NMI_CH0));
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (elig[i]) winner = SEL_W'(i);
        any_elig = |elig;
    end

    // Clear strobes: ACK clears the acknowledged channel, the test port clears the selected one.
    always_comb begin
        ack_clr   = '0;
        test_clr  = '0;
        sel_valid = (int'(TEST_SEL) < NUM_IRQ);
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i]  = (state == INTC_PEND) && ACK && (win_idx == SEL_W'(i));
            test_clr[i] = TEST_STB && (TEST_SEL == SEL_W'(i));
        end
    end

    assign frozen_nmi   = NMI_CH0 && (win_idx == '0);
    assign track_winner = any_elig && ((state == INTC_IDLE) || ((state == INTC_PEND) && !ACK));

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= INTC_IDLE;
        else if (CE)
            state <= next_state;
    end

    // FSM next state: request, re-evaluate while pending, hold during service.
    always_comb begin
        next_state = state;
        case (state)
            INTC_IDLE: if (any_elig) next_state = INTC_PEND;
            INTC_PEND: begin
                if (ACK)
                    next_state = INTC_SERV;
                else if (!any_elig)
                    next_state = INTC_IDLE;
            end
            INTC_SERV: if (!IE_IN || frozen_nmi) next_state = INTC_IDLE;
            default:   next_state = INTC_IDLE;
        endcase
    end

    // Registered outputs: request, vector (frozen from ACK), test result and mask.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            IRQ_REQ  <= 1'b0;
            IRQ_VEC  <= VEC_BASE;
            win_idx  <= '0;
            TEST_HIT <= 1'b0;
            MASK     <= '1;
        end else if (CE) begin
            IRQ_REQ <= (next_state == INTC_PEND);
            if (track_winner) begin
                win_idx <= winner;
                IRQ_VEC <= intc_vec(VEC_BASE, VEC_STRIDE, 32'(winner));
            end
            if (TEST_STB)
                TEST_HIT <= sel_valid ? FLAGS[TEST_SEL] : 1'b0;
            if (MASK_WE)
                MASK <= MASK_D;
        end
    end

endmodule

// File: tb/tb_upd7801_intc.sv
// Scoreboard bench for upd7801_intc with default parameters.
module tb_upd7801_intc;

    typedef enum int {K_REQ, K_VEC, K_FLAGS, K_MASK, K_HIT} kind_t;

    typedef struct {
        int          tag;    // cycle after whose rising edge the value must hold
        kind_t       kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [4:0]  irq_in;
    logic        ie_in;
    logic        mask_we;
    logic [4:0]  mask_d;
    logic        ack;
    logic        test_stb;
    logic [2:0]  test_sel;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        test_hit;
    logic [4:0]  flags;
    logic [4:0]  mask;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    upd7801_intc dut (
        .CLK      (clk),
        .RESET    (reset),
        .CE       (ce),
        .IRQ_IN   (irq_in),
        .IE_IN    (ie_in),
        .MASK_WE  (mask_we),
        .MASK_D   (mask_d),
        .ACK      (ack),
        .TEST_STB (test_stb),
        .TEST_SEL (test_sel),
        .IRQ_REQ  (irq_req),
        .IRQ_VEC  (irq_vec),
        .TEST_HIT (test_hit),
        .FLAGS    (flags),
        .MASK     (mask)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected value for the outputs after the next rising edge.
    task automatic want(input string name, input kind_t k, input logic [15:0] v);
        exp_t e;
        e.tag  = cyc + 1;
        e.kind = k;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and drop single-cycle pulses.
    task automatic tick();
        @(negedge clk);
        ack      = 1'b0;
        test_stb = 1'b0;
        mask_we  = 1'b0;
    endtask

    // Monitor: compare every expectation due at this falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            if (e.tag != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: due at cycle %0d, seen at %0d", e.name, e.tag, cyc);
            end else begin
                case (e.kind)
                    K_REQ:   act = {15'b0, irq_req};
                    K_VEC:   act = irq_vec;
                    K_FLAGS: act = 16'(flags);
                    K_MASK:  act = 16'(mask);
                    K_HIT:   act = {15'b0, test_hit};
                    default: act = 'x;
                endcase
                check(e.name, act, e.val);
            end
        end
        if (done) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: never compared, expected %h", e.name, e.val);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ce = 1'b1; irq_in = '0; ie_in = 1'b1; mask_we = 1'b0;
        mask_d = '0; ack = 1'b0; test_stb = 1'b0; test_sel = '0;

        // Reset state.
        want("rst_req", K_REQ, 16'h0); want("rst_vec", K_VEC, 16'h0004);
        want("rst_flags", K_FLAGS, 16'h0); want("rst_mask", K_MASK, 16'h001F);
        want("rst_hit", K_HIT, 16'h0);
        tick(); tick();
        reset = 1'b0;

        // Rising edge on ch2, unmasked.
        mask_we = 1'b1; mask_d = 5'b00000; want("mask_clear", K_MASK, 16'h0); tick();
        irq_in = 5'b00100; want("t1_flag", K_FLAGS, 16'h4); want("t1_req_lat", K_REQ, 16'h0); tick();
        want("t1_req", K_REQ, 16'h1); want("t1_vec", K_VEC, 16'h000C); tick();
        ack = 1'b1; want("t1_ack_req", K_REQ, 16'h0); want("t1_ack_flag", K_FLAGS, 16'h0);
        want("t1_ack_vec", K_VEC, 16'h000C); tick();
        irq_in = '0; ie_in = 1'b0; want("t1_idle", K_REQ, 16'h0); tick();
        ie_in = 1'b1;

        // New edge on the winner in the ACK cycle keeps the flag set.
        irq_in = 5'b00100; want("sw_flag", K_FLAGS, 16'h4); tick();
        want("sw_req", K_REQ, 16'h1); tick();
        irq_in = '0; tick();
        irq_in = 5'b00100; ack = 1'b1; want("sw_ack_req", K_REQ, 16'h0); want("sw_set_wins", K_FLAGS, 16'h4); tick();
        irq_in = '0; ie_in = 1'b0; tick();
        test_stb = 1'b1; test_sel = 3'd2; want("sw_test_hit", K_HIT, 16'h1); want("sw_test_clr", K_FLAGS, 16'h0); tick();
        ie_in = 1'b1;

        // ch3 and ch1 together: ch1 first, ch3 after IE toggles.
        irq_in = 5'b01010; want("t2_flags", K_FLAGS, 16'h000A); tick();
        want("t2_req", K_REQ, 16'h1); want("t2_vec", K_VEC, 16'h0008); tick();
        ack = 1'b1; want("t2_ack_req", K_REQ, 16'h0); want("t2_ack_flags", K_FLAGS, 16'h0008);
        want("t2_ack_vec", K_VEC, 16'h0008); tick();
        want("t2_serv_hold", K_REQ, 16'h0); tick();
        ie_in = 1'b0; want("t2_ie_low", K_REQ, 16'h0); tick();
        ie_in = 1'b1; want("t2_req3", K_REQ, 16'h1); want("t2_vec3", K_VEC, 16'h0010); tick();
        ack = 1'b1; want("t2_ack3_flags", K_FLAGS, 16'h0); tick();
        ie_in = 1'b0; irq_in = '0; tick();

        // ch0 as NMI with IE low; service ends without IE toggling.
        irq_in = 5'b00001; want("t3_flag0", K_FLAGS, 16'h1); want("t3_req_lat", K_REQ, 16'h0); tick();
        want("t3_nmi_req", K_REQ, 16'h1); want("t3_nmi_vec", K_VEC, 16'h0004); tick();
        ack = 1'b1; irq_in = '0; ie_in = 1'b1; want("t3_ack_req", K_REQ, 16'h0); want("t3_ack_flags", K_FLAGS, 16'h0); tick();
        irq_in = 5'b00010; want("t3_release", K_REQ, 16'h0); want("t3_flag1", K_FLAGS, 16'h2); tick();
        want("t3_after_nmi_req", K_REQ, 16'h1); want("t3_after_nmi_vec", K_VEC, 16'h0008); tick();
        ack = 1'b1; want("t3_ack1_flags", K_FLAGS, 16'h0); tick();
        ie_in = 1'b0; irq_in = '0; tick();

        // ch4 waits for IE.
        irq_in = 5'b10000; want("t3_flag4", K_FLAGS, 16'h0010); tick();
        want("t3_ch4_blocked_a", K_REQ, 16'h0); tick();
        want("t3_ch4_blocked_b", K_REQ, 16'h0); tick();
        ie_in = 1'b1; want("t3_ch4_req", K_REQ, 16'h1); want("t3_ch4_vec", K_VEC, 16'h0014); tick();
        ack = 1'b1; want("t3_ch4_ack_flags", K_FLAGS, 16'h0); tick();
        ie_in = 1'b0; irq_in = '0; tick();
        ie_in = 1'b1;

        // Masked ch2 and the test port.
        mask_we = 1'b1; mask_d = 5'b00100; want("t4_mask", K_MASK, 16'h0004); tick();
        irq_in = 5'b00100; want("t4_flag", K_FLAGS, 16'h4); tick();
        want("t4_masked_a", K_REQ, 16'h0); tick();
        want("t4_masked_b", K_REQ, 16'h0); tick();
        test_stb = 1'b1; test_sel = 3'd2; want("t4_hit", K_HIT, 16'h1); want("t4_clr", K_FLAGS, 16'h0); tick();
        irq_in = '0; want("t4_hit_hold", K_HIT, 16'h1); tick();
        irq_in = 5'b00100; tick();
        test_stb = 1'b1; test_sel = 3'd7; want("t4_sel_oob_hit", K_HIT, 16'h0); want("t4_sel_oob_flags", K_FLAGS, 16'h4); tick();
        test_stb = 1'b1; test_sel = 3'd2; want("t4_hit2", K_HIT, 16'h1); want("t4_clr2", K_FLAGS, 16'h0); tick();
        test_stb = 1'b1; test_sel = 3'd2; want("t4_second_hit", K_HIT, 16'h0); tick();

        // Level ch0 drops before ACK.
        irq_in = 5'b00001; want("t5_flag0", K_FLAGS, 16'h1); tick();
        want("t5_req", K_REQ, 16'h1); want("t5_vec", K_VEC, 16'h0004); tick();
        irq_in = '0; want("t5_still_pend", K_REQ, 16'h1); want("t5_flag_drop", K_FLAGS, 16'h0); tick();
        want("t5_idle", K_REQ, 16'h0); tick();
        ack = 1'b1; want("t5_ack_idle", K_REQ, 16'h0); tick();

        // ch1 preempts pending ch3; CE low holds everything.
        irq_in = 5'b01000; want("t6_flag3", K_FLAGS, 16'h8); tick();
        want("t6_req3", K_REQ, 16'h1); want("t6_vec3", K_VEC, 16'h0010); tick();
        irq_in = 5'b01010; want("t6_flags31", K_FLAGS, 16'h000A); want("t6_vec_lag", K_VEC, 16'h0010); tick();
        want("t6_preempt_req", K_REQ, 16'h1); want("t6_preempt_vec", K_VEC, 16'h0008); tick();
        ce = 1'b0; ack = 1'b1; test_stb = 1'b1; test_sel = 3'd1;
        want("t6_ce0_req", K_REQ, 16'h1); want("t6_ce0_flags", K_FLAGS, 16'h000A); want("t6_ce0_hit", K_HIT, 16'h0); tick();
        ce = 1'b1; ack = 1'b1; test_stb = 1'b1; test_sel = 3'd1;
        want("t6_ack_req", K_REQ, 16'h0); want("t6_ack_test_hit", K_HIT, 16'h1);
        want("t6_ack_test_flags", K_FLAGS, 16'h8); want("t6_ack_vec", K_VEC, 16'h0008); tick();

        // Reset while in service.
        reset = 1'b1; ack = 1'b1; irq_in = '0;
        want("t7_req", K_REQ, 16'h0); want("t7_vec", K_VEC, 16'h0004); want("t7_flags", K_FLAGS, 16'h0);
        want("t7_mask", K_MASK, 16'h001F); want("t7_hit", K_HIT, 16'h0); tick();
        reset = 1'b0; irq_in = 5'b00010; want("t7_flag1", K_FLAGS, 16'h2); tick();
        want("t7_masked_req", K_REQ, 16'h0); tick();

        tick();
        done = 1'b1;
        forever tick();
    end

endmodule
